ic_74hc32: RTL and testbench
============================

IC_74HC32 -- requirements
Module: ic_74hc32

Interface
REQ-001 SHALL have parameter NUM_GATES, default 4: number of gates in the auxiliary OR section (legal range 1-16).
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port n_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in1, input, 1 bit: primary gate input A.
REQ-005 SHALL have port in2, input, 1 bit: primary gate input B.
REQ-006 SHALL have port out, output, 1 bit: primary gate output, in1 OR in2.
REQ-007 SHALL have port a, input, NUM_GATES bits: auxiliary gate A inputs, bit i feeds gate i.
REQ-008 SHALL have port b, input, NUM_GATES bits: auxiliary gate B inputs.
REQ-009 SHALL have port y, output, NUM_GATES bits: auxiliary gate outputs.
REQ-010 SHALL have port out_q, output, 1 bit: registered copy of out.
REQ-011 SHALL have port y_q, output, NUM_GATES bits: registered copy of y.
REQ-012 SHALL have port out_chg, output, 1 bit: one-cycle pulse when out_q changes value.
REQ-013 SHALL order ports as: clk, n_reset, in1, in2, out, a, b, y, out_q, y_q, out_chg.

Function
REQ-014 SHALL drive out = in1 | in2 purely combinationally, with zero clock latency and no dependence on clk or n_reset.
REQ-015 SHALL drive y[i] = a[i] | b[i] combinationally for every i, with the gates independent of each other.
REQ-016 SHALL keep out and y valid and correct while n_reset is low.
REQ-017 SHALL produce out = 0 only when in1 = 0 and in2 = 0, and out = 1 for inputs 01, 10 and 11.
REQ-018 SHALL load out_q <= out and y_q <= y on each rising clk edge while n_reset is high, giving 1-cycle latency.
REQ-019 SHALL set out_chg to 1 for exactly one cycle after each rising edge on which the newly loaded out_q differs from its previous value, and 0 otherwise.
REQ-020 SHALL register a constant-high out for consecutive cycles with out_chg = 0 after the first transition.
REQ-021 SHALL capture the value present at the rising edge when an input changes between edges, with no intermediate glitch visible on out_q.
REQ-022 SHALL propagate X/Z on in1, in2, a or b to the outputs as standard Verilog OR semantics; no sanitisation.

Reset
REQ-023 SHALL clear out_q, y_q and out_chg to 0 immediately on n_reset falling, independent of clk.
REQ-024 SHALL hold the registered outputs at 0 while n_reset is low.
REQ-025 SHALL resume loading on the first rising clk edge after n_reset returns high.
REQ-026 SHALL compare the first post-reset load against the reset value 0, so a first sampled out = 1 yields out_chg = 1.
REQ-027 SHALL clear the registered state when reset is asserted mid-operation, including in the same cycle as a pending out_chg pulse.

Verification
REQ-028 Truth-table sweep: (in1,in2) = 00, 10, 01, 11, 00, applied at 10-unit intervals -> out = 0, 1, 1, 1, 0, each settling within the same timestep.
REQ-029 Auxiliary section: a = 4'b0101, b = 4'b0011 -> y = 4'b0111 combinationally; after one clk edge -> y_q = 4'b0111.
REQ-030 Registered path: out goes 0->1 before edge k -> out_q = 1 and out_chg = 1 after edge k, then out_chg = 0 after edge k+1 with inputs held.
REQ-031 Async reset: drive n_reset low between clock edges while out_q = 1 -> out_q, y_q and out_chg read 0 immediately while out stays 1.
REQ-032 Reset release: with in1 = 1, release n_reset -> the first edge gives out_q = 1 and out_chg = 1.
REQ-033 Glitch filter: toggle in2 high then low entirely between two edges with in1 = 0 -> out pulses, while out_q stays 0 and out_chg stays 0.

Source files
------------

// File: rtl/ic_74hc32.sv
`default_nettype none
// ============================================================================
// Module   : ic_74hc32
// Purpose  : Quad-OR style gate block with combinational outputs, a registered
//            copy of every output and a change-detect pulse on the primary gate.
// Revision : 1.0 - initial release
// ============================================================================
module ic_74hc32 #(
  parameter int NUM_GATES = 4
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 in1,
  input  logic                 in2,
  output logic                 out,
  input  logic [NUM_GATES-1:0] a,
  input  logic [NUM_GATES-1:0] b,
  output logic [NUM_GATES-1:0] y,
  output logic                 out_q,
  output logic [NUM_GATES-1:0] y_q,
  output logic                 out_chg
);

  logic                 w_out;
  logic [NUM_GATES-1:0] w_y;
  logic                 r_out_q;
  logic [NUM_GATES-1:0] r_y_q;
  logic                 r_out_chg;

  // Plain OR keeps X/Z propagation exactly as the language defines it.
  assign w_out = in1 | in2;

  for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_gate
    assign w_y[gi] = a[gi] | b[gi];
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_out_q   <= 1'b0;
      r_y_q     <= '0;
      r_out_chg <= 1'b0;
    end else begin
      r_out_q   <= w_out;
      r_y_q     <= w_y;
      // Compared against the old register, so the first load after reset is
      // measured against the cleared value.
      r_out_chg <= (w_out != r_out_q);
    end
  end

  assign out     = w_out;
  assign y       = w_y;
  assign out_q   = r_out_q;
  assign y_q     = r_y_q;
  assign out_chg = r_out_chg;

endmodule
`default_nettype wire

// File: tb/tb_ic_74hc32.sv
`default_nettype none
// Testbench for ic_74hc32: directed scenarios plus randomized traffic checked
// against a history-based reference model.
module tb_ic_74hc32;

  localparam int N = 4;

  logic         clk;
  logic         n_reset;
  logic         in1, in2;
  logic         out;
  logic [N-1:0] a, b;
  logic [N-1:0] y;
  logic         out_q;
  logic [N-1:0] y_q;
  logic         out_chg;

  int n_cmp = 0;
  int n_err = 0;

  // Model: every value sampled since the last reset, seeded with the reset value.
  bit           hist[$];
  bit [N-1:0]   yhist[$];

  ic_74hc32 #(.NUM_GATES(N)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .in1     (in1),
    .in2     (in2),
    .out     (out),
    .a       (a),
    .b       (b),
    .y       (y),
    .out_q   (out_q),
    .y_q     (y_q),
    .out_chg (out_chg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model_reset();
    hist.delete();
    yhist.delete();
    hist.push_back(1'b0);
    yhist.push_back('0);
  endfunction

  function automatic bit ref_or(input logic x1, input logic x2);
    return (int'(x1) + int'(x2)) > 0;
  endfunction

  function automatic bit [N-1:0] ref_vec(input logic [N-1:0] va, input logic [N-1:0] vb);
    bit [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = ref_or(va[i], vb[i]);
    return r;
  endfunction

  function automatic bit exp_out_q();
    return hist[$];
  endfunction

  function automatic bit [N-1:0] exp_y_q();
    return yhist[$];
  endfunction

  function automatic bit exp_chg();
    if (hist.size() < 2) return 1'b0;
    return hist[$] != hist[$-1];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (n_reset === 1'b1) begin
      hist.push_back(ref_or(in1, in2));
      yhist.push_back(ref_vec(a, b));
    end
    #1;
  endtask

  task automatic test_reset();
    n_reset = 1'b0; in1 = 1'b0; in2 = 1'b0; a = '0; b = '0;
    model_reset();
    #2;
    n_cmp++; if (out_q !== 1'b0) begin n_err++; $display("FAIL reset_out_q: got %b expected 0", out_q); end
    n_cmp++; if (y_q !== '0) begin n_err++; $display("FAIL reset_y_q: got %b expected 0000", y_q); end
    n_cmp++; if (out_chg !== 1'b0) begin n_err++; $display("FAIL reset_chg: got %b expected 0", out_chg); end
    tick();
    in1 = 1'b1; a = 4'b1010; #1;
    n_cmp++; if (out !== 1'b1) begin n_err++; $display("FAIL reset_comb_out: got %b expected 1", out); end
    n_cmp++; if (y !== 4'b1010) begin n_err++; $display("FAIL reset_comb_y: got %b expected 1010", y); end
    tick();
    n_cmp++; if (out_q !== 1'b0) begin n_err++; $display("FAIL reset_hold_out_q: got %b expected 0", out_q); end
    in1 = 1'b0; a = '0;
  endtask

  task automatic test_truth_table();
    logic [1:0] pats [5];
    bit         expv [5];
    pats = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
    expv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      in1 = pats[i][1]; in2 = pats[i][0];
      #0;
      n_cmp++;
      if (out !== expv[i]) begin
        n_err++; $display("FAIL truth_%0d: in=%b got %b expected %b", i, pats[i], out, expv[i]);
      end
      #10;
    end
  endtask

  task automatic test_reset_release();
    @(negedge clk);
    in1 = 1'b1; in2 = 1'b0;
    n_reset = 1'b1;
    model_reset();
    tick();
    n_cmp++; if (out_q !== 1'b1) begin n_err++; $display("FAIL release_out_q: got %b expected 1", out_q); end
    n_cmp++; if (out_chg !== 1'b1) begin n_err++; $display("FAIL release_chg: got %b expected 1", out_chg); end
  endtask

  task automatic test_aux();
    a = 4'b0101; b = 4'b0011; #1;
    n_cmp++; if (y !== 4'b0111) begin n_err++; $display("FAIL aux_y: got %b expected 0111", y); end
    tick();
    n_cmp++; if (y_q !== 4'b0111) begin n_err++; $display("FAIL aux_y_q: got %b expected 0111", y_q); end
    n_cmp++; if (y_q !== exp_y_q()) begin n_err++; $display("FAIL aux_model: got %b expected %b", y_q, exp_y_q()); end
  endtask

  task automatic test_registered();
    in1 = 1'b0; in2 = 1'b0;
    tick(); tick();
    n_cmp++; if (out_q !== 1'b0) begin n_err++; $display("FAIL reg_low: got %b expected 0", out_q); end
    in2 = 1'b1;
    tick();
    n_cmp++; if (out_q !== 1'b1) begin n_err++; $display("FAIL reg_rise_q: got %b expected 1", out_q); end
    n_cmp++; if (out_chg !== 1'b1) begin n_err++; $display("FAIL reg_rise_chg: got %b expected 1", out_chg); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (out_chg !== 1'b0 || out_q !== 1'b1) begin
        n_err++; $display("FAIL reg_hold_%0d: got q=%b chg=%b expected q=1 chg=0", k, out_q, out_chg);
      end
    end
  endtask

  task automatic test_async_reset();
    #3;
    n_reset = 1'b0; model_reset();
    #1;
    n_cmp++;
    if (out_q !== 1'b0 || y_q !== '0 || out_chg !== 1'b0) begin
      n_err++; $display("FAIL async_clear: got q=%b yq=%b chg=%b expected all 0", out_q, y_q, out_chg);
    end
    n_cmp++; if (out !== 1'b1) begin n_err++; $display("FAIL async_out: got %b expected 1", out); end
    // Reset landing on a live change pulse must kill it.
    @(negedge clk);
    n_reset = 1'b1; model_reset();
    tick();
    n_cmp++; if (out_chg !== 1'b1) begin n_err++; $display("FAIL pend_chg: got %b expected 1", out_chg); end
    #2;
    n_reset = 1'b0; model_reset();
    #1;
    n_cmp++;
    if (out_chg !== 1'b0 || out_q !== 1'b0) begin
      n_err++; $display("FAIL pend_clear: got q=%b chg=%b expected 0 0", out_q, out_chg);
    end
    @(negedge clk);
    n_reset = 1'b1; model_reset();
  endtask

  task automatic test_glitch();
    in1 = 1'b0; in2 = 1'b0;
    tick(); tick();
    #2; in2 = 1'b1; #1;
    n_cmp++; if (out !== 1'b1) begin n_err++; $display("FAIL glitch_high: got %b expected 1", out); end
    #2; in2 = 1'b0; #1;
    n_cmp++; if (out !== 1'b0) begin n_err++; $display("FAIL glitch_low: got %b expected 0", out); end
    tick();
    n_cmp++;
    if (out_q !== 1'b0 || out_chg !== 1'b0) begin
      n_err++; $display("FAIL glitch_reg: got q=%b chg=%b expected 0 0", out_q, out_chg);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 300; it++) begin
      in1 = 1'($urandom); in2 = 1'($urandom);
      a = N'($urandom); b = N'($urandom);
      if (n_reset === 1'b0) begin
        n_reset = 1'b1; model_reset();
      end else if ($urandom_range(19) == 0) begin
        n_reset = 1'b0; model_reset();
      end
      #1;
      n_cmp++;
      if (out !== ref_or(in1, in2) || y !== ref_vec(a, b)) begin
        n_err++; $display("FAIL rnd_comb_%0d: got out=%b y=%b expected out=%b y=%b",
                          it, out, y, ref_or(in1, in2), ref_vec(a, b));
      end
      tick();
      n_cmp++;
      if (out_q !== exp_out_q() || y_q !== exp_y_q() || out_chg !== exp_chg()) begin
        n_err++; $display("FAIL rnd_reg_%0d: got q=%b yq=%b chg=%b expected q=%b yq=%b chg=%b",
                          it, out_q, y_q, out_chg, exp_out_q(), exp_y_q(), exp_chg());
      end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_reset_release();
    test_aux();
    test_registered();
    test_async_reset();
    test_glitch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
